// File: rtl/alu_pkg.sv
// Shared types for the operand-capture front end of the switch/adder demo.
// Holds the FSM state encoding, default width and the signed-overflow rule.
package alu_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GOT_A = 2'd1,
        S_EXEC  = 2'd2,
        S_SHOW  = 2'd3
    } op_state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Two's-complement overflow from sign bits: like-signed operands giving an opposite-signed sum.
    function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/rise_detect.sv
// One-cycle pulse on each rising edge of a clk-synchronous level.
// The level register keeps sampling regardless of any soft clear upstream.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic level_in,
    output logic pulse_out
);

    logic btn_q;
    logic btn_d;

    always_comb begin
        btn_d = level_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn_d;
        end
    end

    assign pulse_out = level_in & ~btn_q;

endmodule

// File: rtl/operand_load_fsm.sv
// Captures two operands from the switches on successive button presses, feeds them
// to the external adder and registers the sum, carry and derived flags for display.
module operand_load_fsm
    import alu_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] data_in,
    input  logic         load_btn,
    input  logic         clear,
    input  logic [N-1:0] sum_in,
    input  logic         cout_in,
    output logic [N-1:0] num1,
    output logic [N-1:0] num2,
    output logic [N-1:0] result,
    output logic         carry,
    output logic         zero,
    output logic         overflow,
    output logic         result_valid,
    output logic [1:0]   state
);

    logic press;

    op_state_t    state_q, state_d;
    logic [N-1:0] num1_q, num1_d;
    logic [N-1:0] num2_q, num2_d;
    logic [N-1:0] result_q, result_d;
    logic         carry_q, carry_d;
    logic         zero_q, zero_d;
    logic         overflow_q, overflow_d;
    logic         valid_q, valid_d;

    rise_detect u_rise_detect (
        .clk       (clk),
        .rst       (rst),
        .level_in  (load_btn),
        .pulse_out (press)
    );

    always_comb begin
        state_d    = state_q;
        num1_d     = num1_q;
        num2_d     = num2_q;
        result_d   = result_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        overflow_d = overflow_q;
        valid_d    = valid_q;

        // Soft clear drops everything, including a press seen in the same cycle.
        if (clear) begin
            state_d    = S_IDLE;
            num1_d     = '0;
            num2_d     = '0;
            result_d   = '0;
            carry_d    = 1'b0;
            zero_d     = 1'b0;
            overflow_d = 1'b0;
            valid_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (press) begin
                        num1_d  = data_in;
                        num2_d  = '0;
                        state_d = S_GOT_A;
                    end
                end
                S_GOT_A: begin
                    if (press) begin
                        num2_d  = data_in;
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    result_d   = sum_in;
                    carry_d    = cout_in;
                    zero_d     = (sum_in == '0);
                    overflow_d = add_overflow(num1_q[N-1], num2_q[N-1], sum_in[N-1]);
                    valid_d    = 1'b1;
                    state_d    = S_SHOW;
                end
                S_SHOW: begin
                    // Restart keeps the last result on display but marks it stale.
                    if (press) begin
                        num1_d  = data_in;
                        num2_d  = '0;
                        valid_d = 1'b0;
                        state_d = S_GOT_A;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            num1_q     <= '0;
            num2_q     <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            num1_q     <= num1_d;
            num2_q     <= num2_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

    assign num1         = num1_q;
    assign num2         = num2_q;
    assign result       = result_q;
    assign carry        = carry_q;
    assign zero         = zero_q;
    assign overflow     = overflow_q;
    assign result_valid = valid_q;
    assign state        = state_q;

endmodule
